// File: rtl/ils_instr_gen_pkg.sv
// Shared opcodes, class/state encodings and LFSR polynomial for the ILS
// random instruction-stream generator.
package ils_gen_pkg;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_ALU = 2'd1,
        CLS_LD  = 2'd2,
        CLS_ST  = 2'd3
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_GEN,
        ST_DONE
    } gen_state_t;

    // Galois step, x^32+x^22+x^2+x+1, shifting toward bit 0
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/ils_instr_gen_if.sv
// Instruction offer channel: valid/ready handshake carrying the word and its class.
interface ils_instr_gen_if;
    import ils_gen_pkg::*;

    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    instr_class_t instr_class;

    modport master (output instr_valid, output instr, output instr_class, input instr_ready);
    modport slave  (input instr_valid, input instr, input instr_class, output instr_ready);
endinterface

// File: rtl/ils_instr_gen_lfsr32.sv
// 32-bit Galois LFSR advanced only when step is high; a zero seed becomes 1
// so the register can never lock up.
module ils_lfsr32
    import ils_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_032D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [31:0] state
);

    localparam logic [31:0] INIT = (SEED == '0) ? 32'd1 : SEED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= INIT;
        else if (step)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/ils_instr_gen.sv
// Seeded random RV32 ALU-immediate/load/store stream generator with NOP flush,
// optional length limit and DONE parking. Optional RAW hazard injection: ILS_GEN_HAZARD_EN.
module ils_instr_gen
    import ils_gen_pkg::*;
#(
    parameter logic [31:0] SEED         = 32'h0000_032D,
    parameter int unsigned NUM_INSTRS   = 0,
    parameter int unsigned NOP_FLUSH    = 4,
    parameter int unsigned RS_WINDOW    = 32,
    parameter int unsigned W_ALU        = 8,
    parameter int unsigned W_LD         = 4,
    parameter logic [11:0] MEM_OFF_MASK = 12'hFFF,
    parameter logic [2:0]  LD_F3_MASK   = 3'b100,
    parameter logic [2:0]  ST_F3_MASK   = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    ils_instr_gen_if.master       bus,
    output logic [31:0]           count,
    output logic                  done
);

    localparam logic [4:0] RS_MASK  = 5'(RS_WINDOW - 1);
    localparam logic [4:0] W_ALU_L  = 5'(W_ALU);
    localparam logic [4:0] W_ALD_L  = 5'(W_ALU + W_LD);

    gen_state_t   state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    instr_class_t class_q, class_d;
    logic         valid_q, valid_d;
    logic [31:0]  count_q, count_d, count_inc;
    logic         done_q, done_d;
    logic [31:0]  flush_q, flush_d;

    logic [31:0]  lfsr_a, lfsr_b, src_a, src_b;
    logic         xfer, step;

    logic [31:0]  gen_word;
    instr_class_t gen_class;
    logic [4:0]   rs1, rs2, rd;
    logic [2:0]   f3, funct;
    logic [11:0]  imm, off;
    logic         unused_bits;

    assign xfer = valid_q && bus.instr_ready;
    assign step = xfer && (state_q == ST_GEN);

    ils_lfsr32 #(.SEED(SEED)) u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .state (lfsr_a)
    );

    ils_lfsr32 #(.SEED(SEED ^ 32'h5A5A_5A5A)) u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .state (lfsr_b)
    );

`ifdef ILS_GEN_HAZARD_EN
    logic [4:0] last_rd_q, last_rd_src;
    logic       rd_writer;

    assign rd_writer   = step && (class_q == CLS_ALU || class_q == CLS_LD);
    // The word built on a transfer must see the rd of the word leaving now
    assign last_rd_src = rd_writer ? instr_q[11:7] : last_rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_rd_q <= '0;
        else if (rd_writer)
            last_rd_q <= instr_q[11:7];
    end

    assign unused_bits = ^{src_a[31:29], src_b[31:21]};
`else
    assign unused_bits = ^{src_a[31:29], src_b[31:20]};
`endif

    // Next word is built from the LFSR state that will be current after this edge
    always_comb begin
        src_a     = step ? lfsr_next(lfsr_a) : lfsr_a;
        src_b     = step ? lfsr_next(lfsr_b) : lfsr_b;
        gen_word  = NOP;
        gen_class = CLS_NOP;
        rs1       = src_a[16:12] & RS_MASK;
        rd        = src_a[21:17] & RS_MASK;
        rs2       = src_b[16:12] & RS_MASK;
        f3        = src_a[24:22];
        imm       = src_a[11:0];
        off       = src_b[11:0] & MEM_OFF_MASK;
        funct     = '0;
`ifdef ILS_GEN_HAZARD_EN
        if (src_b[20])
            rs1 = last_rd_src;
`endif
        if ({1'b0, src_a[28:25]} < W_ALU_L) begin
            if (f3 == 3'd1)
                imm = imm & 12'h01F;
            else if (f3 == 3'd5)
                imm = imm & 12'h41F;
            gen_class = CLS_ALU;
            gen_word  = {imm, rs1, f3, rd, OP_IMM};
        end else if ({1'b0, src_a[28:25]} < W_ALD_L) begin
            funct = src_b[19:17] & LD_F3_MASK;
            if (funct == 3'd3 || funct == 3'd6 || funct == 3'd7)
                funct = 3'd2;
            gen_class = CLS_LD;
            gen_word  = {off, rs1, funct, rd, OP_LOAD};
        end else begin
            funct = src_b[19:17] & ST_F3_MASK;
            if (funct >= 3'd3)
                funct = 3'd2;
            gen_class = CLS_ST;
            gen_word  = {off[11:5], rs2, rs1, funct, off[4:0], OP_STORE};
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        class_d   = class_q;
        valid_d   = valid_q;
        count_d   = count_q;
        done_d    = done_q;
        flush_d   = flush_q;
        count_inc = (count_q == '1) ? count_q : count_q + 32'd1;

        case (state_q)
            ST_FLUSH: begin
                if (NOP_FLUSH == 0) begin
                    state_d = ST_GEN;
                    valid_d = enable;
                    instr_d = gen_word;
                    class_d = gen_class;
                end else begin
                    valid_d = 1'b1;
                    instr_d = NOP;
                    class_d = CLS_NOP;
                    if (xfer) begin
                        flush_d = flush_q + 32'd1;
                        if (flush_q + 32'd1 == 32'(NOP_FLUSH)) begin
                            state_d = ST_GEN;
                            valid_d = enable;
                            instr_d = gen_word;
                            class_d = gen_class;
                        end
                    end
                end
            end
            ST_GEN: begin
                if (xfer) begin
                    count_d = count_inc;
                    if (NUM_INSTRS != 0 && count_inc == 32'(NUM_INSTRS)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        instr_d = NOP;
                        class_d = CLS_NOP;
                    end else begin
                        valid_d = enable;
                        instr_d = gen_word;
                        class_d = gen_class;
                    end
                end else if (!valid_q) begin
                    valid_d = enable;
                    instr_d = gen_word;
                    class_d = gen_class;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                instr_d = NOP;
                class_d = CLS_NOP;
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FLUSH;
            instr_q <= NOP;
            class_q <= CLS_NOP;
            valid_q <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            class_q <= class_d;
            valid_q <= valid_d;
            count_q <= count_d;
            done_q  <= done_d;
            flush_q <= flush_d;
        end
    end

    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_class = class_q;
    assign count           = count_q;
    assign done            = done_q;

endmodule

// File: tb/tb_ils_instr_gen.sv
// Scoreboard bench for ils_instr_gen: three configurations checked against a
// behavioural model of the LFSR-driven instruction stream.
module tb_ils_instr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_m, rst_a, rst_s, en_m, en_a, en_s;
    logic [31:0] cnt_m, cnt_a, cnt_s;
    logic        done_m, done_a, done_s;
    int unsigned chk_cnt = 0, pass_cnt = 0;

    ils_instr_gen_if bus_m ();
    ils_instr_gen_if bus_a ();
    ils_instr_gen_if bus_s ();

    ils_instr_gen #(.NUM_INSTRS(10), .NOP_FLUSH(4), .RS_WINDOW(8), .W_ALU(8), .W_LD(4),
                    .LD_F3_MASK(3'b111), .ST_F3_MASK(3'b111)) dut_m (
        .clk(clk), .reset(rst_m), .enable(en_m), .bus(bus_m), .count(cnt_m), .done(done_m));

    ils_instr_gen #(.SEED(32'h0), .NUM_INSTRS(0), .NOP_FLUSH(0), .W_ALU(16), .W_LD(0)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .bus(bus_a), .count(cnt_a), .done(done_a));

    ils_instr_gen #(.NUM_INSTRS(0), .NOP_FLUSH(2), .W_ALU(0), .W_LD(0),
                    .MEM_OFF_MASK(12'h03C), .ST_F3_MASK(3'b000)) dut_s (
        .clk(clk), .reset(rst_s), .enable(en_s), .bus(bus_s), .count(cnt_s), .done(done_s));

    typedef struct {
        int unsigned w_alu, w_ld, nop_flush, num_instrs;
        logic [4:0]  rsmask;
        logic [11:0] offmask;
        logic [2:0]  ldm, stm;
        logic [31:0] a, b;
        logic [4:0]  lrd;
        int unsigned flushed, gens;
    } mdl_t;

    mdl_t m_m, m_a, m_s;
    logic [33:0] q_m[$], q_a[$], q_s[$];

    function automatic logic [31:0] tb_lfsr(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ ({32{s[0]}} & 32'h8020_0003);
    endfunction

    function automatic mdl_t mdl_new(input logic [31:0] seed, input int unsigned w_alu, w_ld,
                                     nop_flush, num_instrs, rs_window,
                                     input logic [11:0] offmask, input logic [2:0] ldm, stm);
        mdl_t m;
        m.w_alu = w_alu; m.w_ld = w_ld; m.nop_flush = nop_flush; m.num_instrs = num_instrs;
        m.rsmask = 5'(rs_window - 1); m.offmask = offmask; m.ldm = ldm; m.stm = stm;
        m.a = (seed == 32'h0) ? 32'd1 : seed;
        m.b = ((seed ^ 32'h5A5A_5A5A) == 32'h0) ? 32'd1 : (seed ^ 32'h5A5A_5A5A);
        m.lrd = 5'd0; m.flushed = 0; m.gens = 0;
        return m;
    endfunction

    // Expected {class, word} of the next transfer
    task automatic mdl_emit(inout mdl_t m, output logic [33:0] e);
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f;
        logic [11:0] imm, o;
        int unsigned draw;
        if (m.flushed < m.nop_flush) begin
            m.flushed++;
            e = {2'd0, 32'h0000_0013};
        end else if (m.num_instrs != 0 && m.gens >= m.num_instrs) begin
            e = {2'd0, 32'h0000_0013};
        end else begin
            rd  = m.a[21:17] & m.rsmask;
            rs1 = m.a[16:12] & m.rsmask;
            rs2 = m.b[16:12] & m.rsmask;
`ifdef ILS_GEN_HAZARD_EN
            if (m.b[20]) rs1 = m.lrd;
`endif
            draw = int'(m.a[28:25]);
            o    = m.b[11:0] & m.offmask;
            if (draw < m.w_alu) begin
                f = m.a[24:22]; imm = m.a[11:0];
                if (f == 3'd1) imm[11:5] = 7'h00;
                if (f == 3'd5) imm[11:5] = {1'b0, imm[10], 5'b0};
                e = {2'd1, imm, rs1, f, rd, 7'h13};
                m.lrd = rd;
            end else if (draw < m.w_alu + m.w_ld) begin
                f = m.b[19:17] & m.ldm;
                if (f inside {3'd3, 3'd6, 3'd7}) f = 3'd2;
                e = {2'd2, o, rs1, f, rd, 7'h03};
                m.lrd = rd;
            end else begin
                f = m.b[19:17] & m.stm;
                if (f > 3'd2) f = 3'd2;
                e = {2'd3, o[11:5], rs2, rs1, f, o[4:0], 7'h23};
            end
            m.a = tb_lfsr(m.a); m.b = tb_lfsr(m.b); m.gens++;
        end
    endtask

    task automatic test_reset();
        rst_m = 1'b1; rst_a = 1'b1; rst_s = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (bus_m.instr_valid !== 1'b0 || bus_m.instr !== 32'h13 || bus_m.instr_class !== 2'd0 ||
            cnt_m !== 32'd0 || done_m !== 1'b0)
            $display("FAIL reset_m: got v=%b i=%h c=%0d n=%0d d=%b want v=0 i=00000013 c=0 n=0 d=0",
                     bus_m.instr_valid, bus_m.instr, bus_m.instr_class, cnt_m, done_m);
        else pass_cnt++;
        chk_cnt++;
        if (bus_a.instr_valid !== 1'b0 || bus_a.instr !== 32'h13 || cnt_a !== 32'd0 || done_a !== 1'b0)
            $display("FAIL reset_a: got v=%b i=%h n=%0d d=%b want v=0 i=00000013 n=0 d=0",
                     bus_a.instr_valid, bus_a.instr, cnt_a, done_a);
        else pass_cnt++;
        chk_cnt++;
        if (bus_s.instr_valid !== 1'b0 || bus_s.instr_class !== 2'd0 || cnt_s !== 32'd0 || done_s !== 1'b0)
            $display("FAIL reset_s: got v=%b c=%0d n=%0d d=%b want v=0 c=0 n=0 d=0",
                     bus_s.instr_valid, bus_s.instr_class, cnt_s, done_s);
        else pass_cnt++;
        rst_m = 1'b0; rst_a = 1'b0; rst_s = 1'b0;
    endtask

    task automatic test_flush_done();
        logic [33:0] e;
        int unsigned n = 0, cyc = 0, exp_cnt;
        m_m = mdl_new(32'h0000_032D, 8, 4, 4, 10, 8, 12'hFFF, 3'b111, 3'b111);
        q_m.delete();
        repeat (20) begin mdl_emit(m_m, e); q_m.push_back(e); end
        en_m = 1'b1; bus_m.instr_ready = 1'b1;
        while (n < 20 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (bus_m.instr_valid && bus_m.instr_ready) begin
                e = q_m.pop_front();
                exp_cnt = (n <= 4) ? 0 : ((n - 4 > 10) ? 10 : n - 4);
                chk_cnt++;
                if (bus_m.instr !== e[31:0] || bus_m.instr_class !== e[33:32])
                    $display("FAIL flush_done_word %0d: got %h/%0d want %h/%0d", n,
                             bus_m.instr, bus_m.instr_class, e[31:0], e[33:32]);
                else pass_cnt++;
                chk_cnt++;
                if (cnt_m !== exp_cnt || done_m !== (n >= 14))
                    $display("FAIL flush_done_count %0d: got n=%0d d=%b want n=%0d d=%b", n,
                             cnt_m, done_m, exp_cnt, (n >= 14));
                else pass_cnt++;
                if (e[33:32] != 2'd0) begin
                    chk_cnt++;
                    if (bus_m.instr[19:15] >= 5'd8 ||
                        ((e[33:32] == 2'd3) ? bus_m.instr[24:20] : bus_m.instr[11:7]) >= 5'd8)
                        $display("FAIL reg_window %0d: got %h want all register fields < 8", n, bus_m.instr);
                    else pass_cnt++;
                end
                n++;
            end
        end
        if (n < 20) begin
            chk_cnt++;
            $display("FAIL flush_done_timeout: got %0d transfers want 20", n);
        end
        @(negedge clk);
        chk_cnt++;
        if (done_m !== 1'b1 || cnt_m !== 32'd10 || bus_m.instr_valid !== 1'b1 || bus_m.instr !== 32'h13)
            $display("FAIL done_park: got d=%b n=%0d v=%b i=%h want d=1 n=10 v=1 i=00000013",
                     done_m, cnt_m, bus_m.instr_valid, bus_m.instr);
        else pass_cnt++;
    endtask

    task automatic test_backpressure_reset();
        logic [33:0] e;
        int unsigned n = 0, cyc = 0;
        @(negedge clk); rst_m = 1'b1;
        @(negedge clk); rst_m = 1'b0;
        m_m = mdl_new(32'h0000_032D, 8, 4, 4, 10, 8, 12'hFFF, 3'b111, 3'b111);
        q_m.delete();
        repeat (30) begin mdl_emit(m_m, e); q_m.push_back(e); end
        en_m = 1'b1; bus_m.instr_ready = 1'b1;
        while (n < 11 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (n == 7) begin
                // hold a GEN word under backpressure with enable dropped
                bus_m.instr_ready = 1'b0; en_m = 1'b0;
                repeat (5) begin
                    chk_cnt++;
                    if (bus_m.instr_valid !== 1'b1 || bus_m.instr !== q_m[0][31:0] ||
                        bus_m.instr_class !== q_m[0][33:32] || cnt_m !== 32'd3)
                        $display("FAIL backpressure_hold: got v=%b i=%h c=%0d n=%0d want v=1 i=%h c=%0d n=3",
                                 bus_m.instr_valid, bus_m.instr, bus_m.instr_class, cnt_m,
                                 q_m[0][31:0], q_m[0][33:32]);
                    else pass_cnt++;
                    @(negedge clk);
                end
                bus_m.instr_ready = 1'b1;
            end
            if (bus_m.instr_valid && bus_m.instr_ready) begin
                e = q_m.pop_front();
                chk_cnt++;
                if (bus_m.instr !== e[31:0] || bus_m.instr_class !== e[33:32])
                    $display("FAIL backpressure_word %0d: got %h/%0d want %h/%0d", n,
                             bus_m.instr, bus_m.instr_class, e[31:0], e[33:32]);
                else pass_cnt++;
                n++;
                if (n == 8) begin
                    @(negedge clk);
                    chk_cnt++;
                    if (bus_m.instr_valid !== 1'b0 || cnt_m !== 32'd4)
                        $display("FAIL idle_no_enable: got v=%b n=%0d want v=0 n=4", bus_m.instr_valid, cnt_m);
                    else pass_cnt++;
                    en_m = 1'b1;
                end
            end
        end
        if (n < 11) begin
            chk_cnt++;
            $display("FAIL backpressure_timeout: got %0d transfers want 11", n);
        end
        @(negedge clk);
        chk_cnt++;
        if (cnt_m !== 32'd7) $display("FAIL pre_reset_count: got %0d want 7", cnt_m);
        else pass_cnt++;
        rst_m = 1'b1;
        #1;
        chk_cnt++;
        if (bus_m.instr_valid !== 1'b0 || bus_m.instr !== 32'h13 || bus_m.instr_class !== 2'd0 ||
            cnt_m !== 32'd0 || done_m !== 1'b0)
            $display("FAIL midstream_reset: got v=%b i=%h c=%0d n=%0d d=%b want v=0 i=00000013 c=0 n=0 d=0",
                     bus_m.instr_valid, bus_m.instr, bus_m.instr_class, cnt_m, done_m);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_m = 1'b0;
        m_m = mdl_new(32'h0000_032D, 8, 4, 4, 10, 8, 12'hFFF, 3'b111, 3'b111);
        q_m.delete();
        repeat (20) begin mdl_emit(m_m, e); q_m.push_back(e); end
        n = 0; cyc = 0;
        while (n < 20 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (bus_m.instr_valid && bus_m.instr_ready) begin
                e = q_m.pop_front();
                chk_cnt++;
                if (bus_m.instr !== e[31:0] || bus_m.instr_class !== e[33:32])
                    $display("FAIL rerun_word %0d: got %h/%0d want %h/%0d", n,
                             bus_m.instr, bus_m.instr_class, e[31:0], e[33:32]);
                else pass_cnt++;
                n++;
            end
        end
        if (n < 20) begin
            chk_cnt++;
            $display("FAIL rerun_timeout: got %0d transfers want 20", n);
        end
    endtask

    task automatic test_alu_only();
        logic [33:0] e;
        int unsigned n = 0, cyc = 0;
        m_a = mdl_new(32'h0, 16, 0, 0, 0, 32, 12'hFFF, 3'b100, 3'b000);
        q_a.delete();
        repeat (200) begin mdl_emit(m_a, e); q_a.push_back(e); end
        en_a = 1'b1; bus_a.instr_ready = 1'b1;
        while (n < 200 && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (bus_a.instr_valid && bus_a.instr_ready) begin
                e = q_a.pop_front();
                chk_cnt++;
                if (bus_a.instr !== e[31:0] || bus_a.instr_class !== e[33:32])
                    $display("FAIL alu_word %0d: got %h/%0d want %h/%0d", n,
                             bus_a.instr, bus_a.instr_class, e[31:0], e[33:32]);
                else pass_cnt++;
                chk_cnt++;
                if (bus_a.instr[6:0] !== 7'h13 || bus_a.instr_class !== 2'd1)
                    $display("FAIL alu_opcode %0d: got op=%h c=%0d want op=13 c=1", n,
                             bus_a.instr[6:0], bus_a.instr_class);
                else pass_cnt++;
                if (e[14:12] == 3'd1) begin
                    chk_cnt++;
                    if (bus_a.instr[31:25] !== 7'h00)
                        $display("FAIL alu_slli_shamt %0d: got %h want 00", n, bus_a.instr[31:25]);
                    else pass_cnt++;
                end
                if (e[14:12] == 3'd5) begin
                    chk_cnt++;
                    if (bus_a.instr[31:25] !== 7'h00 && bus_a.instr[31:25] !== 7'h20)
                        $display("FAIL alu_srli_srai %0d: got %h want 00 or 20", n, bus_a.instr[31:25]);
                    else pass_cnt++;
                end
                n++;
            end
        end
        if (n < 200) begin
            chk_cnt++;
            $display("FAIL alu_timeout: got %0d transfers want 200", n);
        end
        @(negedge clk);
        chk_cnt++;
        if (cnt_a !== 32'd200 || done_a !== 1'b0)
            $display("FAIL alu_unlimited: got n=%0d d=%b want n=200 d=0", cnt_a, done_a);
        else pass_cnt++;
    endtask

    task automatic test_store_only();
        logic [33:0] e;
        int unsigned n = 0, cyc = 0;
        m_s = mdl_new(32'h0000_032D, 0, 0, 2, 0, 32, 12'h03C, 3'b100, 3'b000);
        q_s.delete();
        repeat (60) begin mdl_emit(m_s, e); q_s.push_back(e); end
        en_s = 1'b1;
        while (n < 60 && cyc < 2000) begin
            @(negedge clk); cyc++;
            bus_s.instr_ready = 1'($urandom_range(0, 1));
            if (bus_s.instr_valid && bus_s.instr_ready) begin
                e = q_s.pop_front();
                chk_cnt++;
                if (bus_s.instr !== e[31:0] || bus_s.instr_class !== e[33:32])
                    $display("FAIL store_word %0d: got %h/%0d want %h/%0d", n,
                             bus_s.instr, bus_s.instr_class, e[31:0], e[33:32]);
                else pass_cnt++;
                if (e[33:32] == 2'd3) begin
                    chk_cnt++;
                    if (bus_s.instr[6:0] !== 7'h23 || bus_s.instr[14:12] !== 3'd0 ||
                        ({bus_s.instr[31:25], bus_s.instr[11:7]} & ~12'h03C) !== 12'h000)
                        $display("FAIL store_fields %0d: got %h want op=23 f3=0 offset within 03C", n,
                                 bus_s.instr);
                    else pass_cnt++;
                end
                n++;
            end
        end
        if (n < 60) begin
            chk_cnt++;
            $display("FAIL store_timeout: got %0d transfers want 60", n);
        end
        bus_s.instr_ready = 1'b0;
    endtask

    initial begin
        en_m = 1'b0; en_a = 1'b0; en_s = 1'b0;
        bus_m.instr_ready = 1'b0; bus_a.instr_ready = 1'b0; bus_s.instr_ready = 1'b0;
        test_reset();
        test_flush_done();
        test_backpressure_reset();
        test_alu_only();
        test_store_only();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
